// File: rtl/cam_lru.sv
// rtl/cam_lru.sv - fully-associative key/value CAM with LRU replacement
// Each entry keeps an age: 0 is most recent, camsize_p-1 is the eviction victim.
module cam_lru #(
  parameter int camsize_p = 8,
  parameter int key_w_p   = 16,
  parameter int val_w_p   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic               rw_n_i,
  input  logic [key_w_p-1:0] key_i,
  input  logic [val_w_p-1:0] val_i,
  output logic               valid_o,
  output logic [val_w_p-1:0] val_o
);

  localparam int age_w_lp = $clog2(camsize_p);
  typedef logic [age_w_lp-1:0] age_t;

  logic [camsize_p-1:0] vld;
  logic [key_w_p-1:0]   keys [camsize_p];
  logic [val_w_p-1:0]   vals [camsize_p];
  age_t                 ages [camsize_p];

  logic [camsize_p-1:0] hit;
  logic                 hit_any;
  age_t                 hit_idx;
  age_t                 victim_idx;
  age_t                 touch_idx;
  age_t                 touch_age;
  logic                 do_read;
  logic                 do_write;
  logic                 touch_en;
  logic                 alloc;

  always_comb begin
    for (int i = 0; i < camsize_p; i++) begin
      hit[i] = vld[i] && (keys[i] == key_i);
    end
  end

  // Ages are a permutation, so exactly one entry carries the maximum age.
  always_comb begin
    hit_idx    = '0;
    victim_idx = '0;
    for (int i = 0; i < camsize_p; i++) begin
      if (hit[i]) hit_idx = age_t'(i);
      if (ages[i] == age_t'(camsize_p - 1)) victim_idx = age_t'(i);
    end
  end

  always_comb begin
    hit_any   = |hit;
    do_read   = valid_i && rw_n_i;
    do_write  = valid_i && !rw_n_i;
    touch_en  = (do_read && hit_any) || do_write;
    alloc     = do_write && !hit_any;
    touch_idx = hit_any ? hit_idx : victim_idx;
    touch_age = ages[touch_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      valid_o <= 1'b0;
      val_o   <= '0;
      for (int i = 0; i < camsize_p; i++) begin
        ages[i] <= age_t'(camsize_p - 1 - i);
      end
    end else begin
      valid_o <= do_read && hit_any;
      val_o   <= (do_read && hit_any) ? vals[hit_idx] : '0;
      if (alloc) vld[victim_idx] <= 1'b1;
      if (touch_en) begin
        for (int i = 0; i < camsize_p; i++) begin
          if (age_t'(i) == touch_idx) ages[i] <= '0;
          else if (ages[i] < touch_age) ages[i] <= ages[i] + 1'b1;
        end
      end
    end
  end

  // Key/value storage is qualified by vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      vals[touch_idx] <= val_i;
      if (alloc) keys[victim_idx] <= key_i;
    end
  end

endmodule

// File: tb/tb_cam_lru.sv
// tb/tb_cam_lru.sv - directed vectors, corner sequences and a reference LRU model for cam_lru
module tb_cam_lru;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        rw_n_i;
  logic [15:0] key_i;
  logic [15:0] val_i;
  logic        valid_o;
  logic [15:0] val_o;

  int checks   = 0;
  int failures = 0;

  cam_lru #(.camsize_p(8), .key_w_p(16), .val_w_p(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .rw_n_i(rw_n_i),
    .key_i(key_i), .val_i(val_i), .valid_o(valid_o), .val_o(val_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rw_n;
    logic [15:0] key;
    logic [15:0] val;
    logic        exp_valid;
    logic [15:0] exp_val;
  } vec_t;

  vec_t tbl[$];

  // Reference model: recency list of entry indices, front = most recent.
  logic        m_vld [8];
  logic [15:0] m_key [8];
  logic [15:0] m_val [8];
  int          order[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic rw, input logic [15:0] k, input logic [15:0] vl,
                     input logic ev, input logic [15:0] eval);
    vec_t t;
    t.valid = v; t.rw_n = rw; t.key = k; t.val = vl; t.exp_valid = ev; t.exp_val = eval;
    tbl.push_back(t);
  endtask

  // Called at a negedge; leaves the bench at the next negedge with the response registered.
  task automatic op(input logic v, input logic rw, input logic [15:0] k, input logic [15:0] vl);
    valid_i = v; rw_n_i = rw; key_i = k; val_i = vl;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; rw_n_i = 1'b1; key_i = '0; val_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_val_o", 32'(val_o), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_age%0d", i), 32'(dut.ages[i]), 32'(7 - i));
    rst = 1'b0;
  endtask

  function automatic int count_key(input logic [15:0] k);
    int n = 0;
    for (int i = 0; i < 8; i++) if (dut.vld[i] && dut.keys[i] == k) n++;
    return n;
  endfunction

  task automatic m_touch(input int e);
    for (int i = 0; i < order.size(); i++) begin
      if (order[i] == e) begin
        order.delete(i);
        break;
      end
    end
    order.push_front(e);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; rw_n_i = 1'b1; key_i = '0; val_i = '0;

    // Directed table; from reset, fill order is entry 0, 1, 2, ...
    add(1, 1, 16'h1234, 16'h0000, 0, 16'h0000);
    add(0, 1, 16'hxxxx, 16'hxxxx, 0, 16'h0000);
    add(1, 0, 16'h0001, 16'hAAAA, 0, 16'h0000);
    add(1, 1, 16'h0001, 16'h0000, 1, 16'hAAAA);
    add(1, 0, 16'h0001, 16'h0010, 0, 16'h0000);
    for (int k = 2; k <= 8; k++) add(1, 0, 16'(k), 16'(k * 16), 0, 16'h0000);
    add(1, 1, 16'h0001, 16'h0000, 1, 16'h0010);
    add(1, 0, 16'h0009, 16'h0090, 0, 16'h0000);
    add(1, 1, 16'h0002, 16'h0000, 0, 16'h0000);
    add(1, 1, 16'h0001, 16'h0000, 1, 16'h0010);
    for (int k = 3; k <= 9; k++) add(1, 1, 16'(k), 16'h0000, 1, 16'(k * 16));
    add(1, 0, 16'h000A, 16'h00A0, 0, 16'h0000);
    add(1, 1, 16'h0001, 16'h0000, 0, 16'h0000);
    add(1, 1, 16'h0003, 16'h0000, 1, 16'h0030);
    add(1, 0, 16'h0003, 16'h0033, 0, 16'h0000);
    add(1, 1, 16'h0003, 16'h0000, 1, 16'h0033);
    add(0, 0, 16'hxxxx, 16'hxxxx, 0, 16'h0000);
    add(1, 1, 16'h000A, 16'h0000, 1, 16'h00A0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      op(tbl[i].valid, tbl[i].rw_n, tbl[i].key, tbl[i].val);
      chk($sformatf("tbl%0d_valid_o", i), 32'(valid_o), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_val_o", i), 32'(val_o), 32'(tbl[i].exp_val));
    end

    // Rewriting an existing key never allocates; eviction only after 8 fresh allocations.
    do_reset();
    op(1, 0, 16'h0005, 16'h0055);
    op(1, 0, 16'h0005, 16'h0066);
    chk("dup_after_rewrite", 32'(count_key(16'h0005)), 32'd1);
    for (int k = 0; k < 7; k++) op(1, 0, 16'(16'h0100 + k), 16'(k));
    chk("dup_after_fill", 32'(count_key(16'h0005)), 32'd1);
    op(1, 1, 16'h0005, 16'h0000);
    chk("k5_read_valid", 32'(valid_o), 32'd1);
    chk("k5_read_val", 32'(val_o), 32'h0066);
    for (int k = 0; k < 7; k++) op(1, 0, 16'(16'h0300 + k), 16'(k));
    chk("k5_after_7", 32'(count_key(16'h0005)), 32'd1);
    op(1, 0, 16'h0307, 16'h0007);
    chk("k5_after_8", 32'(count_key(16'h0005)), 32'd0);
    op(1, 1, 16'h0005, 16'h0000);
    chk("k5_evicted_valid", 32'(valid_o), 32'd0);
    chk("k5_evicted_val", 32'(val_o), 32'd0);

    // Reset in the response cycle of a read hit drops the response immediately.
    do_reset();
    op(1, 0, 16'h0003, 16'h0033);
    valid_i = 1'b1; rw_n_i = 1'b1; key_i = 16'h0003;
    @(posedge clk);
    #1;
    chk("pre_rst_valid_o", 32'(valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid_o", 32'(valid_o), 32'd0);
    chk("async_rst_val_o", 32'(val_o), 32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    op(1, 1, 16'h0003, 16'h0000);
    chk("post_rst_read3", 32'(valid_o), 32'd0);
    op(1, 0, 16'h0007, 16'h0077);
    chk("refill_entry0", {31'd0, dut.vld[0] && dut.keys[0] == 16'h0007}, 32'd1);
    chk("refill_entry1_empty", 32'(dut.vld[1]), 32'd0);

    // Random traffic against the recency-list model.
    do_reset();
    order.delete();
    for (int e = 7; e >= 0; e--) order.push_back(e);
    for (int e = 0; e < 8; e++) begin m_vld[e] = 1'b0; m_key[e] = '0; m_val[e] = '0; end
    for (int n = 0; n < 3000; n++) begin
      logic        v;
      logic        rw;
      logic [15:0] k;
      logic [15:0] vl;
      logic        ev;
      logic [15:0] eval;
      int          h;
      v  = ($urandom_range(0, 9) < 8);
      rw = $urandom_range(0, 1) == 1;
      k  = 16'($urandom_range(0, 11));
      vl = 16'($urandom);
      ev = 1'b0; eval = '0; h = -1;
      for (int e = 0; e < 8; e++) if (m_vld[e] && m_key[e] == k) h = e;
      if (v && rw && h >= 0) begin
        ev = 1'b1; eval = m_val[h]; m_touch(h);
      end else if (v && !rw) begin
        if (h >= 0) begin
          m_val[h] = vl; m_touch(h);
        end else begin
          h = order[$];
          m_vld[h] = 1'b1; m_key[h] = k; m_val[h] = vl; m_touch(h);
        end
      end
      op(v, rw, k, vl);
      chk($sformatf("rand%0d_valid_o", n), 32'(valid_o), 32'(ev));
      chk($sformatf("rand%0d_val_o", n), 32'(val_o), 32'(eval));
    end
    begin
      logic [7:0] seen = '0;
      for (int i = 0; i < 8; i++) seen[dut.ages[i]] = 1'b1;
      chk("ages_permutation", 32'(seen), 32'h00FF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
